// File: rtl/cisc_exec_unit.sv
// Execute unit: register file, single-cycle ALU and a shift-add multiplier.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module cisc_exec_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 16,
    localparam int RA = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [RA-1:0]    rd,
    input  logic [RA-1:0]    rs1,
    input  logic [RA-1:0]    rs2,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = WIDTH[CW-1:0];
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH[WIDTH-1:0];

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                 state_q;
    logic [WIDTH-1:0]       regs_q [NREGS];
    logic                   out_valid_q, zero_q, carry_q, err_q;
    logic [WIDTH-1:0]       result_q;
    logic [RA-1:0]          rd_q;
    logic [2*WIDTH-1:0]     mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]       mplier_q;
    logic [CW-1:0]          cnt_q;

    logic [WIDTH-1:0]       op_a, op_b, alu_res;
    logic                   alu_c, alu_err, accept, is_mul;
    logic [WIDTH:0]         sum, shl_w, shr_w;

    assign op_a      = regs_q[rs1];
    assign op_b      = regs_q[rs2];
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    // Shifts run through a WIDTH+1 bit window so the last bit shifted out
    // lands in the extra bit; a zero shift leaves that bit clear.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        sum     = '0;
        shl_w   = '0;
        shr_w   = '0;
        case (opcode)
            OP_ADD: begin
                sum     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                sum     = {1'b0, op_a} - {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_LDI: alu_res = imm;
            OP_ADDI: begin
                sum     = {1'b0, op_a} + {1'b0, imm};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SHL: begin
                if (op_b < W_VAL) begin
                    shl_w   = {1'b0, op_a} << op_b;
                    alu_res = shl_w[WIDTH-1:0];
                    alu_c   = shl_w[WIDTH];
                end
            end
            OP_SHR: begin
                if (op_b < W_VAL) begin
                    shr_w   = {op_a, 1'b0} >> op_b;
                    alu_res = shr_w[WIDTH:1];
                    alu_c   = shr_w[0];
                end
            end
            OP_MUL: ;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                // WIDTH step cycles, then one more cycle to commit the product.
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        regs_q[rd_q] <= acc_q[WIDTH-1:0];
                        result_q     <= acc_q[WIDTH-1:0];
                        zero_q       <= (acc_q[WIDTH-1:0] == '0);
                        carry_q      <= |acc_q[2*WIDTH-1:WIDTH];
                        err_q        <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    if (accept) begin
                        if (is_mul) begin
                            rd_q        <= rd;
                            mcand_q     <= {{WIDTH{1'b0}}, op_a};
                            mplier_q    <= op_b;
                            acc_q       <= '0;
                            cnt_q       <= CNT_INIT;
                            out_valid_q <= 1'b0;
                            state_q     <= S_EXEC;
                        end else begin
                            if (!alu_err) regs_q[rd] <= alu_res;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_c;
                            err_q       <= alu_err;
                            out_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
            endcase
        end
    end

endmodule
